// File: rtl/fsm_table_pkg.sv
// Shared definitions for the table-driven Moore engine.
// Covers state-width derivation, table entry indexing and reset values.
package fsm_table_pkg;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_ADVANCE,
      ACT_RESTART
   } step_act_e;

   localparam logic RESET_PULSE = 1'b0;
   localparam int   RESET_DWELL = 0;

   function automatic int calc_state_w(input int num_states);
      return (num_states <= 2) ? 1 : $clog2(num_states);
   endfunction

   // Each row holds 2^IN_W consecutive entries, one for each input symbol.
   function automatic int entry_index(input int row, input int col, input int in_w);
      return row * (1 << in_w) + col;
   endfunction

endpackage

// File: rtl/fsm_table_store.sv
// Transition and output tables held in flops.
// Each table has one write port with a range check and one combinational read port.
module fsm_table_store
   import fsm_table_pkg::*;
#(
   parameter int NUM_STATES = 6,
   parameter int IN_W       = 2,
   parameter int OUT_W      = 1,
   parameter int STATE_W    = calc_state_w(NUM_STATES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_state,
   input  logic [IN_W-1:0]    cfg_in,
   input  logic [STATE_W-1:0] cfg_next,
   input  logic               cfg_out_we,
   input  logic [OUT_W-1:0]   cfg_out,
   input  logic [STATE_W-1:0] rd_state,
   input  logic [IN_W-1:0]    rd_in,
   output logic [STATE_W-1:0] rd_next,
   output logic [OUT_W-1:0]   rd_out,
   output logic               rd_valid,
   output logic               cfg_err
);

   localparam int NUM_COLS = 1 << IN_W;
   localparam int DEPTH    = NUM_STATES * NUM_COLS;
   localparam int IDX_W    = $clog2(DEPTH);

   logic [STATE_W-1:0] trans_mem [DEPTH];
   logic [OUT_W-1:0]   out_mem   [NUM_STATES];

   logic             state_ok;
   logic             next_ok;
   logic             wr_bad;
   logic             trans_wr;
   logic             out_wr;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // A rejected write is dropped as a whole, even if one half of it was legal.
   always_comb begin
      state_ok = 32'(cfg_state) < NUM_STATES;
      next_ok  = 32'(cfg_next) < NUM_STATES;
      wr_bad   = (cfg_we | cfg_out_we) & (~state_ok | (cfg_we & ~next_ok));
      trans_wr = cfg_we & ~wr_bad;
      out_wr   = cfg_out_we & ~wr_bad;
      wr_idx   = IDX_W'(entry_index(int'(cfg_state), int'(cfg_in), IN_W));
   end

   // The read side depends only on the state register and input symbol, never on cfg_*.
   always_comb begin
      rd_valid = 32'(rd_state) < NUM_STATES;
      rd_idx   = IDX_W'(entry_index(int'(rd_state), int'(rd_in), IN_W));
      rd_next  = '0;
      rd_out   = '0;
      if (rd_valid) begin
         rd_next = trans_mem[rd_idx];
         rd_out  = out_mem[rd_state];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_STATES; r++) begin
            out_mem[r] <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
               trans_mem[IDX_W'(entry_index(r, c, IN_W))] <= STATE_W'(r);
            end
         end
         cfg_err <= RESET_PULSE;
      end else begin
         if (trans_wr) begin
            trans_mem[wr_idx] <= cfg_next;
         end
         if (out_wr) begin
            out_mem[cfg_state] <= cfg_out;
         end
         cfg_err <= wr_bad;
      end
   end

endmodule

// File: rtl/fsm_table_engine.sv
// Run-time programmable Moore sequencer.
// Holds the state register, restart/enable priority, the saturating dwell counter and the change pulse.
module fsm_table_engine
   import fsm_table_pkg::*;
#(
   parameter int  NUM_STATES  = 6,
   parameter int  IN_W        = 2,
   parameter int  OUT_W       = 1,
   parameter int  CNT_W       = 8,
   parameter int  RESET_STATE = 0,
   localparam int STATE_W     = calc_state_w(NUM_STATES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               restart,
   input  logic [IN_W-1:0]    input_signal,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_state,
   input  logic [IN_W-1:0]    cfg_in,
   input  logic [STATE_W-1:0] cfg_next,
   input  logic               cfg_out_we,
   input  logic [OUT_W-1:0]   cfg_out,
   output logic [OUT_W-1:0]   output_signal,
   output logic [STATE_W-1:0] current_state,
   output logic               state_changed,
   output logic [CNT_W-1:0]   dwell_cnt,
   output logic               cfg_err
);

   localparam logic [STATE_W-1:0] RST_STATE = STATE_W'(RESET_STATE);

   logic [STATE_W-1:0] table_next;
   logic [OUT_W-1:0]   table_out;
   logic               state_valid;
   logic [STATE_W-1:0] next_state;
   logic [CNT_W-1:0]   next_dwell;
   logic [CNT_W-1:0]   dwell_sat;
   logic               next_changed;
   step_act_e          act;

   fsm_table_store #(
      .NUM_STATES (NUM_STATES),
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .STATE_W    (STATE_W)
   ) u_store (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg_we     (cfg_we),
      .cfg_state  (cfg_state),
      .cfg_in     (cfg_in),
      .cfg_next   (cfg_next),
      .cfg_out_we (cfg_out_we),
      .cfg_out    (cfg_out),
      .rd_state   (current_state),
      .rd_in      (input_signal),
      .rd_next    (table_next),
      .rd_out     (table_out),
      .rd_valid   (state_valid),
      .cfg_err    (cfg_err)
   );

   assign output_signal = table_out;
   assign dwell_sat     = (&dwell_cnt) ? dwell_cnt : dwell_cnt + CNT_W'(1);

   // Restart beats enable. An out-of-range state is pulled back to RESET_STATE on the next advance.
   always_comb begin
      act          = ACT_HOLD;
      next_state   = current_state;
      next_dwell   = dwell_sat;
      next_changed = 1'b0;
      if (restart) begin
         act = ACT_RESTART;
      end else if (en) begin
         act = ACT_ADVANCE;
      end
      case (act)
         ACT_RESTART: begin
            next_state   = RST_STATE;
            next_dwell   = '0;
            next_changed = (current_state != RST_STATE);
         end
         ACT_ADVANCE: begin
            next_state = state_valid ? table_next : RST_STATE;
            if (next_state != current_state) begin
               next_dwell   = '0;
               next_changed = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         current_state <= RST_STATE;
         dwell_cnt     <= CNT_W'(RESET_DWELL);
         state_changed <= RESET_PULSE;
      end else begin
         current_state <= next_state;
         dwell_cnt     <= next_dwell;
         state_changed <= next_changed;
      end
   end

endmodule

// File: tb/tb_fsm_table_engine.sv
// Randomised and directed bench for fsm_table_engine.
// Compares the DUT against a table-array reference model of the controller.
module tb_fsm_table_engine;

   localparam int NS      = 6;
   localparam int IW      = 2;
   localparam int OW      = 1;
   localparam int CW      = 4;
   localparam int SW      = 3;
   localparam int NI      = 1 << IW;
   localparam int DMAX    = (1 << CW) - 1;
   localparam int RST     = 0;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en;
   logic          restart;
   logic [IW-1:0] input_signal;
   logic          cfg_we;
   logic [SW-1:0] cfg_state;
   logic [IW-1:0] cfg_in;
   logic [SW-1:0] cfg_next;
   logic          cfg_out_we;
   logic [OW-1:0] cfg_out;
   logic [OW-1:0] output_signal;
   logic [SW-1:0] current_state;
   logic          state_changed;
   logic [CW-1:0] dwell_cnt;
   logic          cfg_err;

   int trans_m [NS][NI];
   int out_m   [NS];
   int m_state;
   int m_dwell;
   int m_changed;
   int m_err;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fsm_table_engine #(
      .NUM_STATES  (NS),
      .IN_W        (IW),
      .OUT_W       (OW),
      .CNT_W       (CW),
      .RESET_STATE (RST)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en),
      .restart       (restart),
      .input_signal  (input_signal),
      .cfg_we        (cfg_we),
      .cfg_state     (cfg_state),
      .cfg_in        (cfg_in),
      .cfg_next      (cfg_next),
      .cfg_out_we    (cfg_out_we),
      .cfg_out       (cfg_out),
      .output_signal (output_signal),
      .current_state (current_state),
      .state_changed (state_changed),
      .dwell_cnt     (dwell_cnt),
      .cfg_err       (cfg_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int r = 0; r < NS; r++) begin
         out_m[r] = 0;
         for (int c = 0; c < NI; c++) trans_m[r][c] = r;
      end
      m_state   = RST;
      m_dwell   = 0;
      m_changed = 0;
      m_err     = 0;
   endtask

   task automatic checkModel();
      checkOutput("state",   32'(current_state), m_state);
      checkOutput("output",  32'(output_signal), out_m[m_state]);
      checkOutput("changed", 32'(state_changed), m_changed);
      checkOutput("dwell",   32'(dwell_cnt),     m_dwell);
      checkOutput("cfg_err", 32'(cfg_err),       m_err);
   endtask

   // Drives one cycle at the falling edge, advances the model, checks just after the rising edge.
   task automatic applyStimulus(input logic a_en, input logic a_restart, input int a_in,
                                input logic a_we, input int a_st, input int a_col, input int a_next,
                                input logic a_owe, input int a_out);
      int nxt;
      int err;
      en           = a_en;
      restart      = a_restart;
      input_signal = IW'(a_in);
      cfg_we       = a_we;
      cfg_state    = SW'(a_st);
      cfg_in       = IW'(a_col);
      cfg_next     = SW'(a_next);
      cfg_out_we   = a_owe;
      cfg_out      = OW'(a_out);
      err = ((a_we || a_owe) && (a_st >= NS || (a_we && a_next >= NS))) ? 1 : 0;
      if (a_restart) begin
         nxt       = RST;
         m_changed = (m_state != RST) ? 1 : 0;
         m_dwell   = 0;
      end else if (a_en) begin
         nxt = trans_m[m_state][a_in];
         if (nxt != m_state) begin
            m_changed = 1;
            m_dwell   = 0;
         end else begin
            m_changed = 0;
            m_dwell   = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
         end
      end else begin
         nxt       = m_state;
         m_changed = 0;
         m_dwell   = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
      end
      if (err == 0) begin
         if (a_we)  trans_m[a_st][a_col] = a_next;
         if (a_owe) out_m[a_st] = a_out;
      end
      m_state = nxt;
      m_err   = err;
      @(posedge clk);
      #1;
      checkModel();
      @(negedge clk);
   endtask

   task automatic stepIn(input int a_in);
      applyStimulus(1'b1, 1'b0, a_in, 1'b0, 0, 0, 0, 1'b0, 0);
   endtask

   task automatic writeT(input int st, input int col, input int nx);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, st, col, nx, 1'b0, 0);
   endtask

   task automatic writeO(input int st, input int o);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, st, 0, 0, 1'b1, o);
   endtask

   initial begin
      reset_n = 1'b0;
      en = 1'b0; restart = 1'b0; input_signal = '0;
      cfg_we = 1'b0; cfg_state = '0; cfg_in = '0; cfg_next = '0;
      cfg_out_we = 1'b0; cfg_out = '0;
      modelReset();
      #1;
      checkOutput("rst_state",   32'(current_state), 0);
      checkOutput("rst_output",  32'(output_signal), 0);
      checkOutput("rst_changed", 32'(state_changed), 0);
      checkOutput("rst_dwell",   32'(dwell_cnt),     0);
      checkOutput("rst_err",     32'(cfg_err),       0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         stepIn(i % 4);
         checkOutput("dflt_dwell", 32'(dwell_cnt), i + 1);
      end

      writeT(0, 1, 1);
      writeT(1, 1, 3);
      writeT(3, 3, 5);
      writeT(5, 2, 0);
      writeO(0, 1);
      writeO(2, 1);
      writeO(4, 1);
      stepIn(1);
      checkOutput("seq_s1", 32'(current_state), 1);
      stepIn(1);
      checkOutput("seq_s3", 32'(current_state), 3);
      stepIn(3);
      checkOutput("seq_s5", 32'(current_state), 5);
      checkOutput("seq_s5_out", 32'(output_signal), 0);
      stepIn(2);
      checkOutput("seq_s0", 32'(current_state), 0);
      checkOutput("seq_s0_out", 32'(output_signal), 1);

      applyStimulus(1'b1, 1'b0, 1, 1'b1, 0, 1, 2, 1'b0, 0);
      checkOutput("coll_old", 32'(current_state), 1);
      applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b0, 0);
      checkOutput("coll_restart", 32'(current_state), 0);
      stepIn(1);
      checkOutput("coll_new", 32'(current_state), 2);

      writeT(6, 0, 1);
      checkOutput("bad_row_err", 32'(cfg_err), 1);
      stepIn(0);
      checkOutput("bad_row_clear", 32'(cfg_err), 0);
      writeT(0, 0, 7);
      checkOutput("bad_next_err", 32'(cfg_err), 1);
      writeO(7, 1);
      stepIn(0);
      checkOutput("bad_unchanged", 32'(current_state), 2);

      writeT(2, 0, 3);
      stepIn(0);
      checkOutput("dw_s3", 32'(current_state), 3);
      repeat (20) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 0);
      checkOutput("dw_sat", 32'(dwell_cnt), 15);
      applyStimulus(1'b1, 1'b1, 3, 1'b0, 0, 0, 0, 1'b0, 0);
      checkOutput("prio_state", 32'(current_state), 0);
      checkOutput("prio_dwell", 32'(dwell_cnt), 0);
      checkOutput("prio_changed", 32'(state_changed), 1);

      writeT(0, 3, 5);
      stepIn(3);
      checkOutput("ar_s5", 32'(current_state), 5);
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("ar_state", 32'(current_state), 0);
      checkOutput("ar_dwell", 32'(dwell_cnt), 0);
      checkOutput("ar_changed", 32'(state_changed), 0);
      @(negedge clk);
      reset_n = 1'b1;
      stepIn(1);
      stepIn(3);
      stepIn(2);
      checkOutput("ar_hold0", 32'(current_state), 0);
      checkOutput("ar_out0", 32'(output_signal), 0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       int'($urandom_range(0, NI - 1)),
                       $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, NI - 1)), int'($urandom_range(0, 6)),
                       $urandom_range(0, 3) == 0, int'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
